// File: rtl/activity_tracker_pkg.sv
// Shared state encodings, default thresholds and a saturating adder for the
// activity tracker.
package activity_tracker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    CAND = 2'd1,
    HIGH = 2'd2
  } hi_state_e;

  localparam int DEF_SI_THRESH  = 32;
  localparam int DEF_WINDOW_SEC = 9;
  localparam int DEF_HI_THRESH  = 64;
  localparam int DEF_HI_MIN_SEC = 60;
  localparam int DEF_SAT_STEPS  = 9999;

  // 16-bit add that clamps at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/activity_tracker_hi_act_fsm.sv
// High-activity run detector. A run of HI_MIN_SEC consecutive qualifying
// seconds credits HI_MIN_SEC at once; each further qualifying second credits 1.
// A non-qualifying second drops back to LOW and forfeits an uncredited run.
//
// state | meaning
// LOW   | no qualifying run in progress
// CAND  | run in progress, runLen seconds so far, nothing credited yet
// HIGH  | run has been credited, each further qualifying second credits 1
module hi_act_fsm
  import activity_tracker_pkg::*;
#(
  parameter int HI_MIN_SEC = DEF_HI_MIN_SEC
) (
  input  logic        lightClk,
  input  logic        reset,
  input  logic        tick,
  input  logic        qualify,
  output logic        creditStrobe,
  output logic [15:0] amount
);

  hi_state_e   state_q, state_d;
  logic [6:0]  run_len_q, run_len_d;

  // State and run-length registers, synchronous reset
  always_ff @(posedge lightClk) begin
    if (reset) begin
      state_q   <= LOW;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
    end
  end

  // Next state, run length and credit for the current second
  always_comb begin
    state_d      = state_q;
    run_len_d    = run_len_q;
    creditStrobe = 1'b0;
    amount       = '0;
    if (tick) begin
      case (state_q)
        LOW: begin
          if (qualify) begin
            state_d   = CAND;
            run_len_d = 7'd1;
          end
        end
        CAND: begin
          if (qualify) begin
            run_len_d = run_len_q + 7'd1;
            if (run_len_d == 7'(HI_MIN_SEC)) begin
              creditStrobe = 1'b1;
              amount       = 16'(HI_MIN_SEC);
              state_d      = HIGH;
            end
          end else begin
            state_d   = LOW;
            run_len_d = '0;
          end
        end
        HIGH: begin
          if (qualify) begin
            creditStrobe = 1'b1;
            amount       = 16'd1;
          end else begin
            state_d   = LOW;
            run_len_d = '0;
          end
        end
        default: begin
          state_d   = LOW;
          run_len_d = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/activity_tracker.sv
// Step activity tracker: per-second step rate, early-window over-threshold
// count, credited high-activity time, distance and saturation flag.
//
// state | meaning
// IDLE  | paused, second ticks ignored, counters hold
// RUN   | tracking, each second tick samples the step delta
module activity_tracker
  import activity_tracker_pkg::*;
#(
  parameter int SI_THRESH  = DEF_SI_THRESH,
  parameter int WINDOW_SEC = DEF_WINDOW_SEC,
  parameter int HI_THRESH  = DEF_HI_THRESH,
  parameter int HI_MIN_SEC = DEF_HI_MIN_SEC,
  parameter int SAT_STEPS  = DEF_SAT_STEPS
) (
  input  logic        lightClk,
  input  logic        reset,
  input  logic        start,
  input  logic        secTick,
  input  logic [15:0] stepCount,
  output logic [15:0] stepsPerSec,
  output logic [5:0]  distHalfMi,
  output logic [3:0]  overSecs,
  output logic [15:0] hiActSecs,
  output logic        satInd
);

  run_state_e  run_q, run_d;
  logic [15:0] prev_q, prev_d;
  logic [7:0]  elapsed_q, elapsed_d;
  logic [15:0] sps_q, sps_d;
  logic [3:0]  over_q, over_d;
  logic [15:0] hi_q, hi_d;
  logic [5:0]  dist_q;
  logic        sat_q;

  logic [15:0] delta;
  logic        run_tick;
  logic        credit;
  logic [15:0] credit_amt;

  // Modular subtraction keeps the delta correct across 16-bit counter wrap
  assign delta    = stepCount - prev_q;
  assign run_tick = (run_q == RUN) && secTick;

  hi_act_fsm #(
    .HI_MIN_SEC (HI_MIN_SEC)
  ) u_hi_act_fsm (
    .lightClk     (lightClk),
    .reset        (reset),
    .tick         (run_tick),
    .qualify      (delta >= 16'(HI_THRESH)),
    .creditStrobe (credit),
    .amount       (credit_amt)
  );

  // Tracking registers plus the free-running distance and saturation samples
  always_ff @(posedge lightClk) begin
    if (reset) begin
      run_q     <= IDLE;
      prev_q    <= '0;
      elapsed_q <= '0;
      sps_q     <= '0;
      over_q    <= '0;
      hi_q      <= '0;
      dist_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      prev_q    <= prev_d;
      elapsed_q <= elapsed_d;
      sps_q     <= sps_d;
      over_q    <= over_d;
      hi_q      <= hi_d;
      dist_q    <= stepCount[15:10];
      sat_q     <= (stepCount > 16'(SAT_STEPS));
    end
  end

  // Run/pause control and per-second updates
  always_comb begin
    run_d     = run_q;
    prev_d    = prev_q;
    elapsed_d = elapsed_q;
    sps_d     = sps_q;
    over_d    = over_q;
    hi_d      = hi_q;
    case (run_q)
      IDLE: begin
        if (start) begin
          run_d  = RUN;
          prev_d = stepCount;
        end
      end
      RUN: begin
        if (!start) run_d = IDLE;
      end
      default: run_d = IDLE;
    endcase
    if (run_tick) begin
      sps_d  = delta;
      prev_d = stepCount;
      if (elapsed_q != 8'hFF) elapsed_d = elapsed_q + 8'd1;
      if ((delta > 16'(SI_THRESH)) && (elapsed_q < 8'(WINDOW_SEC)) && (over_q != 4'hF))
        over_d = over_q + 4'd1;
    end
    if (credit) hi_d = sat_add16(hi_q, credit_amt);
  end

  assign stepsPerSec = sps_q;
  assign distHalfMi  = dist_q;
  assign overSecs    = over_q;
  assign hiActSecs   = hi_q;
  assign satInd      = sat_q;

endmodule

// File: doc/activity_tracker.md
ACTIVITY_TRACKER -- requirements
Module: activity_tracker

Interface
REQ-001 Parameter SI_THRESH, default 32, steps/second strictly exceeded to count a second as "over-threshold".
REQ-002 Parameter WINDOW_SEC, default 9, number of initial running seconds in which over-threshold seconds are counted.
REQ-003 Parameter HI_THRESH, default 64, minimum steps/second for a high-activity second.
REQ-004 Parameter HI_MIN_SEC, default 60, consecutive high-activity seconds before time is credited.
REQ-005 Parameter SAT_STEPS, default 9999, step count above which satInd asserts.
REQ-006 lightClk  input  1  clock; all state updates on posedge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  run enable; high = tracking, low = paused.
REQ-009 secTick  input  1  one-cycle strobe, once per second, synchronous to lightClk.
REQ-010 stepCount  input  16  running step total from the upstream step counter.
REQ-011 stepsPerSec  output  16  steps counted in the most recently completed second.
REQ-012 distHalfMi  output  6  distance in 0.5-mile units (1024 steps per unit).
REQ-013 overSecs  output  4  over-threshold seconds within the first WINDOW_SEC running seconds.
REQ-014 hiActSecs  output  16  total credited high-activity seconds.
REQ-015 satInd  output  1  high when stepCount > SAT_STEPS.

Function
REQ-016 FSM states: IDLE, RUN; reset -> IDLE; IDLE -> RUN when start=1; RUN -> IDLE when start=0.
REQ-017 On IDLE -> RUN transition, prevCount SHALL load stepCount so no spurious delta is produced.
REQ-018 In RUN with secTick=1: delta = stepCount - prevCount, 16-bit modular (wrap-safe); stepsPerSec <= delta; prevCount <= stepCount; elapsed second counter increments, saturating at 255.
REQ-019 secTick in IDLE SHALL be ignored; all outputs hold their values while paused.
REQ-020 overSecs increments on a secTick when delta > SI_THRESH and elapsed count (before increment) < WINDOW_SEC; saturates at 15.
REQ-021 High-activity sub-FSM: LOW, CAND, HIGH; runLen counter 7 bits.
REQ-022 LOW: delta >= HI_THRESH -> CAND, runLen=1; else stay.
REQ-023 CAND: delta >= HI_THRESH -> runLen+1; if runLen+1 == HI_MIN_SEC then hiActSecs += HI_MIN_SEC and -> HIGH; delta < HI_THRESH -> LOW, runLen=0, nothing credited.
REQ-024 HIGH: delta >= HI_THRESH -> hiActSecs += 1; else -> LOW, runLen=0.
REQ-025 hiActSecs SHALL saturate at 65535, never wrap.
REQ-026 Sub-FSM advances only on secTick in RUN; RUN -> IDLE holds sub-FSM state and runLen.
REQ-027 distHalfMi <= stepCount[15:10] every cycle (1-cycle latency), independent of start.
REQ-028 satInd <= (stepCount > SAT_STEPS) every cycle (1-cycle latency).
REQ-029 stepsPerSec, overSecs, hiActSecs update at the secTick edge; visible next cycle.

Reset
REQ-030 reset=1 at a posedge SHALL clear all outputs, prevCount, elapsed count, runLen to 0 and set FSM to IDLE, sub-FSM to LOW.
REQ-031 reset SHALL win over simultaneous secTick, start, or any mid-run state, including CAND with runLen=HI_MIN_SEC-1.

Structure
REQ-032 Shared package holds FSM state encodings (IDLE/RUN, LOW/CAND/HIGH) and default threshold constants.
REQ-033 One sub-module, hi_act_fsm, SHALL implement REQ-021..REQ-025 with inputs tick, qualify, reset and output creditStrobe/amount.

Verification
REQ-034 Run 9 s at 40 steps/s then 5 s at 40 -> overSecs=9, stepsPerSec=40.
REQ-035 Run 59 s at 70 steps/s then 1 s at 10 -> hiActSecs=0, sub-FSM LOW.
REQ-036 Run 62 s at 70 steps/s -> hiActSecs=60 after tick 60, 62 after tick 62.
REQ-037 prevCount=65530, stepCount 4 at next secTick -> stepsPerSec=10.
REQ-038 stepCount=10000 -> satInd=1, distHalfMi=9; stepCount=2048 -> distHalfMi=2, satInd=0.
REQ-039 reset asserted with secTick in CAND runLen=30 -> all outputs 0, LOW, next 59 qualifying ticks credit nothing.
